// File: rtl/fir_tdm_mc_if.sv
// rtl/fir_tdm_mc_if.sv - coefficient, sample, result and status signals of fir_tdm_mc
interface fir_tdm_mc_if #(
  parameter int DW   = 18,
  parameter int CW   = 25,
  parameter int OW   = 18,
  parameter int TAPS = 32,
  parameter int CH   = 2
);
  localparam int AW  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  logic [CW-1:0]  coef_din;
  logic [AW-1:0]  coef_addr;
  logic           coef_we;
  logic [31:0]    len;
  logic [DW-1:0]  in_data;
  logic [CHW-1:0] in_ch;
  logic           in_valid;
  logic           in_ready;
  logic [OW-1:0]  out_data;
  logic [CHW-1:0] out_ch;
  logic           out_valid;
  logic           busy;
  logic           sat;
  logic           coef_err;
  logic           flag_clr;

  modport master (
    output coef_din, coef_addr, coef_we, in_data, in_ch, in_valid, flag_clr,
    input  len, in_ready, out_data, out_ch, out_valid, busy, sat, coef_err
  );

  modport slave (
    input  coef_din, coef_addr, coef_we, in_data, in_ch, in_valid, flag_clr,
    output len, in_ready, out_data, out_ch, out_valid, busy, sat, coef_err
  );
endinterface

// File: rtl/fir_tdm_mc.sv
// rtl/fir_tdm_mc.sv - time-multiplexed multi-channel FIR, optional decimation under FIR_TDM_DECIM_EN
module fir_tdm_mc #(
  parameter int DW        = 18,
  parameter int CW        = 25,
  parameter int OW        = 18,
  parameter int TAPS      = 32,
  parameter int CH        = 2,
  parameter int ACCW      = 48,
  parameter int OUT_SHIFT = 19,
  parameter int DECIM     = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  fir_tdm_mc_if.slave   bus
);
  localparam int AW  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int AW1 = AW + 1;
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
  localparam int PW  = DW + CW;
  localparam int RW  = ACCW + 1;

  localparam logic [CW-1:0]        COEF_UNITY = {{(CW-1){1'b0}}, 1'b1} << OUT_SHIFT;
  localparam logic signed [RW-1:0] HALF       = {{(RW-1){1'b0}}, 1'b1} << (OUT_SHIFT - 1);
  localparam logic signed [RW-1:0] OMAX       = RW'({1'b0, {(OW-1){1'b1}}});
  localparam logic signed [RW-1:0] OMIN       = ~OMAX;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND} state_t;

  state_t                state_q;
  logic signed [CW-1:0]  coef_q  [TAPS];
  logic signed [DW-1:0]  dline_q [CH][TAPS];
  logic [AW-1:0]         wptr_q  [CH];
  logic [AW-1:0]         k_q;
  logic [CHW-1:0]        ch_q;
  logic signed [ACCW-1:0] acc_q;
  logic                  in_ready_q;
  logic                  busy_q;
  logic                  out_valid_q;
  logic [OW-1:0]         out_data_q;
  logic [CHW-1:0]        out_ch_q;
  logic                  sat_q;
  logic                  coef_err_q;

  logic                  ch_ok;
  logic                  accept;
  logic                  run_mac;
  logic                  coef_addr_ok;
  logic                  coef_wr_ok;
  logic                  coef_drop;
  logic                  k_last;
  logic [AW-1:0]         rd_base;
  logic [AW-1:0]         rd_idx;
  logic signed [PW-1:0]  prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] acc_d;
  logic signed [RW-1:0]  rnd_sum;
  logic signed [RW-1:0]  rnd_shr;
  logic [OW-1:0]         out_data_d;
  logic                  clamp_hit;
  logic                  sat_d;
  logic                  coef_err_d;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(TAPS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ch_ok        = int'(bus.in_ch) < CH;
  assign accept       = (state_q == S_IDLE) && in_ready_q && bus.in_valid && ch_ok;
  assign coef_addr_ok = {1'b0, bus.coef_addr} < AW1'(TAPS);
  assign coef_wr_ok   = bus.coef_we && !busy_q && coef_addr_ok;
  assign coef_drop    = bus.coef_we && !coef_wr_ok;
  assign k_last       = (k_q == AW'(TAPS - 1));

`ifdef FIR_TDM_DECIM_EN
  localparam int PHW = (DECIM > 1) ? $clog2(DECIM) : 1;
  logic [PHW-1:0] phase_q [CH];

  assign run_mac = (phase_q[bus.in_ch] == PHW'(DECIM - 1));

  // per-channel decimation phase, advanced by every accepted sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CH; c++) phase_q[c] <= '0;
    end else if (accept) begin
      phase_q[bus.in_ch] <= run_mac ? '0 : phase_q[bus.in_ch] + 1'b1;
    end
  end
`else
  logic unused_decim;
  assign run_mac      = 1'b1;
  assign unused_decim = |DECIM;
`endif

  // circular read address: newest sample minus tap index, modulo TAPS
  always_comb begin
    rd_base = wptr_q[ch_q];
    if (rd_base >= k_q) rd_idx = rd_base - k_q;
    else                rd_idx = AW'(AW1'(rd_base) + AW1'(TAPS) - AW1'(k_q));
  end

  assign prod     = coef_q[k_q] * dline_q[ch_q][rd_idx];
  assign prod_ext = ACCW'(prod);
  assign acc_d    = acc_q + prod_ext;

  // round half up, then clamp into the signed output range
  always_comb begin
    rnd_sum    = RW'(acc_q) + HALF;
    rnd_shr    = rnd_sum >>> OUT_SHIFT;
    out_data_d = rnd_shr[OW-1:0];
    clamp_hit  = 1'b0;
    if (rnd_shr > OMAX) begin
      out_data_d = OMAX[OW-1:0];
      clamp_hit  = 1'b1;
    end else if (rnd_shr < OMIN) begin
      out_data_d = OMIN[OW-1:0];
      clamp_hit  = 1'b1;
    end
  end

  // coefficient bank; tap 0 resets to unity gain so the filter passes through
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int t = 0; t < TAPS; t++) coef_q[t] <= (t == 0) ? $signed(COEF_UNITY) : '0;
    end else if (coef_wr_ok) begin
      coef_q[bus.coef_addr] <= $signed(bus.coef_din);
    end
  end

  // delay lines: write on accept, advance the channel pointer after its last tap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CH; c++) begin
        wptr_q[c] <= '0;
        for (int t = 0; t < TAPS; t++) dline_q[c][t] <= '0;
      end
    end else begin
      if (accept) dline_q[bus.in_ch][wptr_q[bus.in_ch]] <= $signed(bus.in_data);
      if (accept && !run_mac) wptr_q[bus.in_ch] <= wrap_inc(wptr_q[bus.in_ch]);
      if (state_q == S_MAC && k_last) wptr_q[ch_q] <= wrap_inc(wptr_q[ch_q]);
    end
  end

  // control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      ch_q        <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          if (accept && run_mac) begin
            state_q    <= S_MAC;
            ch_q       <= bus.in_ch;
            k_q        <= '0;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_MAC: begin
          acc_q <= acc_d;
          if (k_last) state_q <= S_ROUND;
          else        k_q     <= k_q + 1'b1;
        end
        S_ROUND: begin
          out_data_q  <= out_data_d;
          out_ch_q    <= ch_q;
          out_valid_q <= 1'b1;
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign sat_d      = bus.flag_clr ? 1'b0 : (sat_q | ((state_q == S_ROUND) && clamp_hit));
  assign coef_err_d = bus.flag_clr ? 1'b0 : (coef_err_q | coef_drop);

  // sticky status flags; a clear wins over a same-cycle set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_q      <= 1'b0;
      coef_err_q <= 1'b0;
    end else begin
      sat_q      <= sat_d;
      coef_err_q <= coef_err_d;
    end
  end

  assign bus.len       = 32'(TAPS);
  assign bus.in_ready  = in_ready_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sat       = sat_q;
  assign bus.coef_err  = coef_err_q;
endmodule

// File: tb/tb_fir_tdm_mc.sv
// tb/tb_fir_tdm_mc.sv - self-checking bench for fir_tdm_mc
module tb_fir_tdm_mc;
  localparam int TAPS = 32;
  localparam int CH   = 2;
  localparam int OS   = 19;
  localparam int CHW  = 1;
  localparam longint OMAX = 131071;
  localparam longint OMIN = -131072;

  logic clk;
  logic reset_n;

  fir_tdm_mc_if #(.DW(18), .CW(25), .OW(18), .TAPS(TAPS), .CH(CH)) bus ();
  fir_tdm_mc_if #(.DW(18), .CW(25), .OW(18), .TAPS(6), .CH(1)) bus6 ();

  fir_tdm_mc #(.DW(18), .CW(25), .OW(18), .TAPS(TAPS), .CH(CH), .ACCW(48), .OUT_SHIFT(OS), .DECIM(1))
    dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  fir_tdm_mc #(.DW(18), .CW(25), .OW(18), .TAPS(6), .CH(1), .ACCW(48), .OUT_SHIFT(OS), .DECIM(1))
    dut6 (.clk(clk), .reset_n(reset_n), .bus(bus6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  longint mc [TAPS];
  longint hist [CH][TAPS];
  bit     exp_sat;

  typedef struct {
    longint coef0;
    longint x;
    longint y;
    bit     s;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) mc[k] = 0;
    mc[0] = 64'sd1 <<< OS;
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < TAPS; k++) hist[c][k] = 0;
    exp_sat = 1'b0;
  endtask

  // newest sample at index 0; output is the rounded, clamped dot product
  function automatic longint model_step(int ch, longint x);
    longint s;
    longint r;
    for (int k = TAPS - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
    hist[ch][0] = x;
    s = 0;
    for (int k = 0; k < TAPS; k++) s += mc[k] * hist[ch][k];
    r = (s + (64'sd1 <<< (OS - 1))) >>> OS;
    if (r > OMAX) begin r = OMAX; exp_sat = 1'b1; end
    else if (r < OMIN) begin r = OMIN; exp_sat = 1'b1; end
    return r;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic wr_coef(input int addr, input longint val);
    bus.coef_addr = 5'(addr);
    bus.coef_din  = 25'(val);
    bus.coef_we   = 1'b1;
    @(negedge clk);
    bus.coef_we   = 1'b0;
    mc[addr] = val;
  endtask

  // mode 1: dropped write while busy; mode 2: same plus flag_clr in that cycle
  task automatic send(input int ch, input longint x, input int mode, output longint got);
    int n;
    int w;
    longint exp;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    chk("in_ready_before_send", longint'(bus.in_ready), 1);
    bus.in_ch    = CHW'(ch);
    bus.in_data  = 18'(x);
    bus.in_valid = 1'b1;
    if (mode != 0) begin
      bus.coef_addr = 5'd0;
      bus.coef_din  = 25'(77777);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    exp = model_step(ch, x);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < TAPS + 10) begin
      @(negedge clk);
      n++;
      bus.coef_we  = (mode != 0 && n == 4);
      bus.flag_clr = (mode == 2 && n == 4);
    end
    bus.coef_we  = 1'b0;
    bus.flag_clr = 1'b0;
    chk("latency", n, TAPS + 1);
    got = longint'($signed(bus.out_data));
    chk("out_data_vs_model", got, exp);
    chk("out_ch", longint'(bus.out_ch), ch);
    @(negedge clk);
    chk("out_valid_single_cycle", longint'(bus.out_valid), 0);
  endtask

  longint got;
  bit     seen;

  initial begin
    reset_n = 1'b0;
    bus.coef_din = '0;  bus.coef_addr = '0;  bus.coef_we = 1'b0;
    bus.in_data = '0;   bus.in_ch = '0;      bus.in_valid = 1'b0;  bus.flag_clr = 1'b0;
    bus6.coef_din = '0; bus6.coef_addr = '0; bus6.coef_we = 1'b0;
    bus6.in_data = '0;  bus6.in_ch = '0;     bus6.in_valid = 1'b0; bus6.flag_clr = 1'b0;

    vt[0] = '{64'sd1 <<< 19, 1000, 1000, 1'b0};
    vt[1] = '{64'sd1 <<< 18, 3, 2, 1'b0};
    vt[2] = '{64'sd1 <<< 18, -3, -1, 1'b0};
    vt[3] = '{64'sd1 <<< 18, 1, 1, 1'b0};
    vt[4] = '{64'sd1 <<< 18, -1, 0, 1'b0};
    vt[5] = '{64'sd4 <<< 19, 131071, 131071, 1'b1};
    vt[6] = '{64'sd4 <<< 19, -131072, -131072, 1'b1};
    vt[7] = '{64'sd1 <<< 19, -131072, -131072, 1'b0};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_data", longint'(bus.out_data), 0);
    chk("rst_out_ch", longint'(bus.out_ch), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_sat", longint'(bus.sat), 0);
    chk("rst_coef_err", longint'(bus.coef_err), 0);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rst_in_ready", longint'(bus.in_ready), 1);
    chk("len", longint'(bus.len), TAPS);

    // unity impulse then the delay line drains to zero
    send(0, 1000, 0, got);
    chk("impulse_1000", got, 1000);
    for (int i = 0; i < TAPS - 1; i++) begin
      send(0, 0, 0, got);
      chk("impulse_tail_zero", got, 0);
    end

    // rounding and saturation vectors on tap 0
    for (int i = 0; i < 8; i++) begin
      wr_coef(0, vt[i].coef0);
      send(0, vt[i].x, 0, got);
      chk("vec_out", got, vt[i].y);
      chk("vec_sat", longint'(bus.sat), vt[i].s);
      bus.flag_clr = 1'b1;
      @(negedge clk);
      bus.flag_clr = 1'b0;
      chk("vec_sat_cleared", longint'(bus.sat), 0);
      exp_sat = 1'b0;
    end

    // four-tap ramp on ch1 with ch0 zeros interleaved
    do_reset();
    for (int k = 0; k < 4; k++) wr_coef(k, longint'(k + 1) <<< OS);
    for (int i = 0; i < 5; i++) begin
      send(1, (i == 0) ? 1 : 0, 0, got);
      chk("ramp_ch1", got, (i < 4) ? i + 1 : 0);
      send(0, 0, 0, got);
      chk("ramp_ch0_zero", got, 0);
    end

    // coefficient write while busy is dropped; flag_clr wins over same-cycle set
    chk("coef_err_clear_before", longint'(bus.coef_err), 0);
    send(1, 100, 1, got);
    chk("coef_err_busy_write", longint'(bus.coef_err), 1);
    send(1, -250, 0, got);
    send(1, 300, 2, got);
    chk("coef_err_clr_priority", longint'(bus.coef_err), 0);

    // out-of-range address on the six-tap instance
    bus6.coef_addr = 3'd5; bus6.coef_din = 25'(5); bus6.coef_we = 1'b1;
    @(negedge clk);
    bus6.coef_we = 1'b0;
    chk("taps6_len", longint'(bus6.len), 6);
    chk("taps6_inrange_no_err", longint'(bus6.coef_err), 0);
    bus6.coef_addr = 3'd6; bus6.coef_we = 1'b1;
    @(negedge clk);
    bus6.coef_we = 1'b0;
    chk("taps6_addr_eq_taps_err", longint'(bus6.coef_err), 1);

    // randomized coefficients and samples against the model
    do_reset();
    for (int k = 0; k < TAPS; k++)
      wr_coef(k, longint'($urandom_range(0, 2097152)) - 1048576);
    for (int i = 0; i < 40; i++)
      send(int'($urandom_range(0, 1)), longint'($urandom_range(0, 262143)) - 131072, 0, got);
    chk("random_sat_flag", longint'(bus.sat), longint'(exp_sat));

    // asynchronous reset in the middle of MAC
    bus.in_ch = 1'b0; bus.in_data = 18'(700); bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_mid_mac", longint'(bus.busy), 1);
    #2 reset_n = 1'b0;
    #1 chk("async_reset_busy", longint'(bus.busy), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    seen = 1'b0;
    for (int i = 0; i < TAPS + 6; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    chk("no_out_valid_after_reset", longint'(seen), 0);
    chk("in_ready_after_reset", longint'(bus.in_ready), 1);
    send(0, 500, 0, got);
    chk("passthrough_after_reset", got, 500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_tdm_mc.md
Name: fir_tdm_mc

Overview:
- Parametrised, time-multiplexed multi-channel FIR. Successor to the fully-parallel single-channel FIR cell chain.
- One shared multiply-accumulate engine runs TAPS cycles per accepted sample. Each channel has its own circular delay line.
- Coefficients are held in a register bank, loaded by address in the same clock domain.
- Output path rounds and saturates. Sits between the ADC/decimation front end and demodulators.

Parameters:
- DW, 18, input sample width (signed)
- CW, 25, coefficient width (signed)
- OW, 18, output width (signed)
- TAPS, 32, number of taps (>=2)
- CH, 2, number of channels (>=1)
- ACCW, 48, accumulator width
- OUT_SHIFT, 19, arithmetic right shift applied to the accumulator before output (1..ACCW-OW)
- DECIM, 1, decimation factor per channel (used only with the optional feature)

Ports:
- clk, in, 1: clock
- reset_n, in, 1: asynchronous active-low reset
- coef_din, in, CW: coefficient write data
- coef_addr, in, clog2(TAPS): tap index to write
- coef_we, in, 1: coefficient write strobe
- len, out, 32: constant TAPS, readable by software
- in_data, in, DW: input sample
- in_ch, in, clog2(CH) (min 1): channel of the input sample
- in_valid, in, 1: input sample valid
- in_ready, out, 1: engine can accept a sample
- out_data, out, OW: filtered output
- out_ch, out, clog2(CH) (min 1): channel of out_data
- out_valid, out, 1: single-cycle output strobe
- busy, out, 1: engine not idle
- sat, out, 1: sticky saturation flag
- coef_err, out, 1: sticky flag, set when a coefficient write was dropped
- flag_clr, in, 1: clears sat and coef_err

Behaviour:
- Reset (async assert, sync release):
  - Outputs: out_data=0, out_ch=0, out_valid=0, busy=0, sat=0, coef_err=0, in_ready=1 once released.
  - All delay lines and write pointers = 0. FSM = IDLE.
  - coef[0] = 1<<OUT_SHIFT (unity passthrough); all other coef = 0.
- FSM states IDLE -> MAC -> ROUND -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid with in_ch<CH, the sample is accepted. It is written to buf[in_ch][wptr[in_ch]] and the channel is latched.
  - acc=0, k=0, go to MAC.
  - in_ch>=CH: sample is dropped, no state change.
- MAC, one tap per cycle for k=0..TAPS-1:
  - acc += coef[k] * buf[ch][(wptr[ch]-k) mod TAPS].
  - Products are full precision (DW+CW bits), sign-extended to ACCW. The accumulator wraps on overflow and does not saturate.
  - After k=TAPS-1: wptr[ch] = wptr[ch]+1 mod TAPS. Go to ROUND. in_ready=0 throughout.
- ROUND (1 cycle):
  - r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, i.e. round half up.
  - Clamp r to [-(2^(OW-1)), 2^(OW-1)-1]. Set sat if clamped.
  - Register out_data and out_ch, pulse out_valid for 1 cycle. Return to IDLE.
- Latency: accept edge at cycle 0 -> out_valid at cycle TAPS+1. Maximum throughput is one sample per TAPS+2 cycles across all channels.
- busy = (state != IDLE).
- Coefficient writes:
  - Honoured only while busy=0. Take effect next cycle.
  - A write while busy=1 is dropped and sets coef_err.
  - A write with coef_addr>=TAPS is ignored and sets coef_err.
  - A write in the same cycle as a sample accept is honoured before MAC starts.
- Flags: flag_clr has priority over a same-cycle set, so the flags read 0 on the next cycle.
- Reset mid-MAC: the computation is abandoned, no out_valid, all state returns to reset values.
- Channels are independent: a sample on one channel never reads another channel's delay line.

Optional Feature:
- Macro: FIR_TDM_DECIM_EN.
- With the macro defined:
  - A per-channel phase counter 0..DECIM-1 is added.
  - Every accepted sample is written to the delay line and advances wptr.
  - MAC/ROUND run only when phase==DECIM-1. Other samples return to IDLE the next cycle with no out_valid.
  - Phase wraps to 0 after DECIM-1 and resets to 0.
- Without the macro: DECIM is ignored and every accepted sample produces an output.

Test Plan:
- Post-reset impulse: in_data=1000 on ch0 -> out_valid at cycle TAPS+1 with out_data=1000, out_ch=0. The next 31 zero samples give 0.
- Load coef[k]=(k+1)<<OUT_SHIFT for k=0..3, others 0. Impulse of 1 on ch1 -> successive ch1 outputs 1,2,3,4,0. Interleaved ch0 zeros give 0 throughout.
- Saturation: coef[0]=4<<OUT_SHIFT, in_data=2^17-1 -> out_data=131071, sat=1. Then flag_clr -> sat=0.
- Rounding: coef[0]=1<<(OUT_SHIFT-1), in_data=3 -> out_data=2 (1.5 rounds up). in_data=-3 -> out_data=-1.
- Coefficient write while busy -> dropped and coef_err=1. Write with coef_addr=TAPS -> ignored and coef_err=1.
- Async reset asserted mid-MAC -> no out_valid. Afterwards in_ready=1 and an impulse reproduces unity passthrough.
